// File: rtl/he_out_framer_if.sv
// Pixel stream interface of the HE output framer.
// slave: framer side (accepts in_*, drives out_*); master: peer side.
interface he_out_framer_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pixel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pixel;
  logic              out_sof;
  logic              out_sol;
  logic              out_eol;
  logic              out_eof;

  modport slave (
    input  in_valid,
    input  in_pixel,
    output in_ready,
    output out_valid,
    output out_pixel,
    output out_sof,
    output out_sol,
    output out_eol,
    output out_eof,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_pixel,
    input  in_ready,
    input  out_valid,
    input  out_pixel,
    input  out_sof,
    input  out_sol,
    input  out_eol,
    input  out_eof,
    output out_ready
  );
endinterface

// File: rtl/he_out_framer.sv
// HE output framer: tags raster pixels with sof/sol/eol/eof, buffers
// them in a FIFO for a backpressuring sink and counts frames.
// Ports: clk, reset (async, active low), bus (slave stream),
// frame_done (pulse after eof pop), frame_count (16-bit, wraps).
module he_out_framer #(
  parameter int IMAGE_WIDTH  = 660,
  parameter int IMAGE_HEIGHT = 440,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATA_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  he_out_framer_if.slave     bus,
  output logic               frame_done,
  output logic [15:0]        frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (IMAGE_WIDTH > 1) ?
                      $clog2(IMAGE_WIDTH) : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ?
                      $clog2(IMAGE_HEIGHT) : 1;
  localparam int EW = DATA_W + 4;

  localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);

  logic [AW:0]     wptr_q, wptr_d;
  logic [AW:0]     rptr_q, rptr_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            fd_q, fd_d;
  logic [15:0]     fc_q, fc_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];

  logic            full, empty;
  logic            push, pop;
  logic            col_last, row_last;
  logic            t_sof, t_sol, t_eol, t_eof;
  logic [EW-1:0]   wdata;
  logic [EW-1:0]   head;

  // Full: same slot index, opposite lap bit.
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);

  // Held low while reset is asserted; otherwise state-only.
  assign bus.in_ready  = reset & ~full;
  assign bus.out_valid = ~empty;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = ~empty & bus.out_ready;

  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  assign t_sol = (col_q == '0);
  assign t_sof = t_sol & (row_q == '0);
  assign t_eol = col_last;
  assign t_eof = col_last & row_last;

  assign wdata = {bus.in_pixel, t_sof, t_sol, t_eol, t_eof};
  assign head  = mem_q[rptr_q[AW-1:0]];

  // Outputs come from stored entries only; zero when nothing is held.
  always_comb begin
    bus.out_pixel = '0;
    bus.out_sof   = 1'b0;
    bus.out_sol   = 1'b0;
    bus.out_eol   = 1'b0;
    bus.out_eof   = 1'b0;
    if (!empty) begin
      {bus.out_pixel, bus.out_sof, bus.out_sol,
       bus.out_eol, bus.out_eof} = head;
    end
  end

  always_comb begin
    col_d  = col_q;
    row_d  = row_q;
    wptr_d = wptr_q + {{AW{1'b0}}, push};
    rptr_d = rptr_q + {{AW{1'b0}}, pop};
    fd_d   = pop & head[0];
    fc_d   = fc_q;
    if (push) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
    if (fd_d) begin
      fc_d = fc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      fd_q   <= 1'b0;
      fc_q   <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      col_q  <= col_d;
      row_q  <= row_d;
      fd_q   <= fd_d;
      fc_q   <= fc_d;
    end
  end

  // Storage needs no reset: reads are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

  assign frame_done  = fd_q;
  assign frame_count = fc_q;

endmodule

// File: doc/he_out_framer.md
Name: he_out_framer

Overview:
- Downstream stage of the HE histogram-equalization core: consumes the raster stream of transformed pixels and re-frames it for the image writer / DMA sink.
- Tags each pixel with start-of-frame, start-of-line, end-of-line and end-of-frame markers from internal column/row counters.
- Buffers pixels in a small FIFO so the sink can apply backpressure without losing data; counts completed frames.

Parameters:
IMAGE_WIDTH, 660, pixels per line
IMAGE_HEIGHT, 440, lines per frame
FIFO_DEPTH, 16, buffer entries (power of 2, >=2)
DATA_W, 8, pixel width

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  transformed pixel present on in_pixel
in_pixel  in  DATA_W  transformed pixel from HE core
in_ready  out  1  framer accepts in_pixel this cycle
out_valid  out  1  out_* fields hold a valid pixel
out_pixel  out  DATA_W  buffered pixel
out_sof  out  1  pixel is (row 0, col 0)
out_sol  out  1  pixel is col 0
out_eol  out  1  pixel is col IMAGE_WIDTH-1
out_eof  out  1  pixel is (row IMAGE_HEIGHT-1, col IMAGE_WIDTH-1)
out_ready  in  1  sink consumes head pixel this cycle
frame_done  out  1  one-cycle pulse, eof pixel consumed by sink
frame_count  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, col=0, row=0, in_ready=0 while asserted, out_valid=0, all out_* tags 0, out_pixel=0, frame_done=0, frame_count=0. Reset mid-frame discards all buffered pixels and partial counts; next accepted pixel is tagged sof.
- Push: in_valid & in_ready. in_ready = !full (combinational from state only, never from in_valid/out_ready). Push while full impossible; a pop in the same cycle does not open in_ready.
- Pop: out_valid & out_ready. out_valid = !empty. out_* driven from FIFO head (registered storage, no combinational path from in_* to out_*).
- Latency: pixel pushed into empty FIFO appears at out_valid on the next rising edge (1 cycle). Simultaneous push and pop: occupancy unchanged, order preserved.
- Each entry stores {pixel, sof, sol, eol, eof}; tags computed at push time from col/row counters.
- Counters advance only on push: col increments; at col=IMAGE_WIDTH-1 col->0 and row increments; at row=IMAGE_HEIGHT-1 and col=IMAGE_WIDTH-1 both -> 0.
- out_valid=0 with out_ready=1: no effect. in_valid=0: counters hold.
- Pointers: log2(FIFO_DEPTH)+1-bit read/write pointers; full when MSBs differ and low bits equal, empty when equal. Pointer wrap at FIFO_DEPTH is seamless.
- frame_done: registered, high exactly the cycle after a pop whose head entry has eof=1; frame_count increments on that same edge.
- out_* held stable while out_valid=1 and out_ready=0 (AXI-stream-like rules).
- IMAGE_WIDTH=1 or IMAGE_HEIGHT=1 legal: sol and eol (or sof and eof) may coincide on one pixel.

Test Plan:
- Params W=4,H=3,DEPTH=4; release reset, stream 12 pixels 0x00..0x0B with out_ready=1 -> outputs match 1 cycle later; sof on 0x00; sol on 0x00,0x04,0x08; eol on 0x03,0x07,0x0B; eof on 0x0B; frame_done pulse the cycle after 0x0B pops; frame_count=1.
- Hold out_ready=0, push 0xA0..0xA3 -> in_ready drops after 4th push; out_pixel holds 0xA0. Raise out_ready -> 0xA0..0xA3 drain in order, in_ready returns 1 the cycle after first pop.
- Full FIFO with in_valid=1 and out_ready=1 same cycle -> no push accepted that cycle; next cycle push accepted; no pixel lost or duplicated across 20 random-backpressure cycles.
- Assert reset mid-frame after 6 pixels (2 buffered) -> out_valid=0 immediately, frame_count=0; next pixel 0x55 tagged sof and sol.
- Stream 3 back-to-back frames (36 pixels) with out_ready toggling every cycle -> exactly 3 frame_done pulses, frame_count=3, sof every 12th output pixel.
- Force frame_count to 0xFFFF (or run 65536 frames with W=H=1) -> next frame_done wraps frame_count to 0x0000; W=H=1 pixel carries sof/sol/eol/eof all high.
